// File: rtl/cn_serial.sv
`default_nettype none
// ============================================================================
// Module      : cn_serial
// Description : Serial min-sum LDPC check-node unit. Collects DEG signed
//               variable-to-check messages, then returns DEG check-to-variable
//               messages in edge order together with a parity-check flag.
//               Optional feature macro: CN_OFFSET_EN (offset min-sum).
// Revision    : 1.0 - initial release
// ============================================================================
module cn_serial #(
    parameter int                    INT        = 8,
    parameter int                    FRAC       = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEG        = 6,
    parameter logic [DATA_WIDTH-1:0] OFFSET     = DATA_WIDTH'('h40)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vr_valid,
    output logic                   vr_ready,
    input  logic [DATA_WIDTH-1:0]  vr_msg,
    output logic                   ch_valid,
    input  logic                   ch_ready,
    output logic [DATA_WIDTH-1:0]  ch_msg,
    output logic [$clog2(DEG)-1:0] ch_idx,
    output logic                   ch_last,
    output logic                   parity_ok
);

    localparam int                    c_cw       = $clog2(DEG);
    localparam logic [c_cw-1:0]       c_last_idx = c_cw'(DEG - 1);
    localparam logic [DATA_WIDTH-1:0] c_mag_max  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_collect = 2'd1;
    localparam logic [1:0] c_st_emit    = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_vr_ready;
    logic                  r_ch_valid;
    logic [DATA_WIDTH-1:0] r_ch_msg;
    logic [c_cw-1:0]       r_ch_idx;
    logic                  r_ch_last;
    logic                  r_parity_ok;

    logic [c_cw-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_min1;
    logic [DATA_WIDTH-1:0] r_min2;
    logic [c_cw-1:0]       r_idx1;
    logic                  r_sgn_acc;
    logic [DEG-1:0]        r_sgn;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_load_first;
    logic                  w_load_next;
    logic [DATA_WIDTH-1:0] w_mag;
    logic [DATA_WIDTH-1:0] w_min1_n;
    logic [DATA_WIDTH-1:0] w_min2_n;
    logic [c_cw-1:0]       w_idx1_n;
    logic                  w_sgn_n;
    logic [c_cw-1:0]       w_next_idx;
    logic                  w_unused_cfg;

    // Format parameters only document the Q format; keep them referenced.
    assign w_unused_cfg = ^{OFFSET, 32'(INT), 32'(FRAC)};

    // Output message for one edge: exclude-self minimum, optional offset, then sign.
    function automatic logic [DATA_WIDTH-1:0] f_edge_msg(
        input logic [c_cw-1:0]       j,
        input logic [c_cw-1:0]       idx1,
        input logic [DATA_WIDTH-1:0] min1,
        input logic [DATA_WIDTH-1:0] min2,
        input logic                  neg
    );
        logic [DATA_WIDTH-1:0] m;
        m = (j == idx1) ? min2 : min1;
`ifdef CN_OFFSET_EN
        m = (m > OFFSET) ? (m - OFFSET) : '0;
`endif
        return neg ? (-m) : m;
    endfunction

    // State register plus look-ahead registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_vr_ready <= 1'b0;
            r_ch_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vr_ready <= (w_state_nxt != c_st_emit);
            r_ch_valid <= (w_state_nxt == c_st_emit);
        end
    end

    // Next-state logic: IDLE -> COLLECT on first input, EMIT after DEG inputs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (w_in_fire) w_state_nxt = c_st_collect;
            c_st_collect: if (w_in_fire && (r_cnt == c_last_idx)) w_state_nxt = c_st_emit;
            c_st_emit:    if (w_out_fire && r_ch_last) w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    // Handshake decode and output-register load strobes.
    always_comb begin
        w_in_fire    = vr_valid && r_vr_ready;
        w_out_fire   = r_ch_valid && ch_ready;
        w_load_first = w_in_fire && (r_state == c_st_collect) && (r_cnt == c_last_idx);
        w_load_next  = w_out_fire && !r_ch_last;
    end

    // Saturated magnitude of the incoming message and updated running minima.
    always_comb begin
        if (vr_msg == c_most_neg) begin
            w_mag = c_mag_max;
        end else if (vr_msg[DATA_WIDTH-1]) begin
            w_mag = -vr_msg;
        end else begin
            w_mag = vr_msg;
        end
        w_min1_n = r_min1;
        w_min2_n = r_min2;
        w_idx1_n = r_idx1;
        if (w_mag < r_min1) begin
            w_min2_n = r_min1;
            w_min1_n = w_mag;
            w_idx1_n = r_cnt;
        end else if (w_mag < r_min2) begin
            w_min2_n = w_mag;
        end
        w_sgn_n    = r_sgn_acc ^ vr_msg[DATA_WIDTH-1];
        w_next_idx = r_ch_idx + 1'b1;
    end

    // Running min/sign state: updated per input, re-initialised after the last output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_min1    <= c_mag_max;
            r_min2    <= c_mag_max;
            r_idx1    <= '0;
            r_sgn_acc <= 1'b0;
            r_sgn     <= '0;
        end else if (w_in_fire) begin
            r_sgn[r_cnt] <= vr_msg[DATA_WIDTH-1];
            r_sgn_acc    <= w_sgn_n;
            r_min1       <= w_min1_n;
            r_min2       <= w_min2_n;
            r_idx1       <= w_idx1_n;
            r_cnt        <= (r_cnt == c_last_idx) ? '0 : (r_cnt + 1'b1);
        end else if (w_out_fire && r_ch_last) begin
            r_cnt     <= '0;
            r_min1    <= c_mag_max;
            r_min2    <= c_mag_max;
            r_idx1    <= '0;
            r_sgn_acc <= 1'b0;
        end
    end

    // Output registers: edge 0 loads on entry to EMIT, later edges on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_msg    <= '0;
            r_ch_idx    <= '0;
            r_ch_last   <= 1'b0;
            r_parity_ok <= 1'b0;
        end else if (w_load_first) begin
            r_ch_msg    <= f_edge_msg('0, w_idx1_n, w_min1_n, w_min2_n, w_sgn_n ^ r_sgn[0]);
            r_ch_idx    <= '0;
            r_ch_last   <= 1'b0;
            r_parity_ok <= ~w_sgn_n;
        end else if (w_load_next) begin
            r_ch_msg    <= f_edge_msg(w_next_idx, r_idx1, r_min1, r_min2,
                                      r_sgn_acc ^ r_sgn[w_next_idx]);
            r_ch_idx    <= w_next_idx;
            r_ch_last   <= (w_next_idx == c_last_idx);
        end
    end

    assign vr_ready  = r_vr_ready;
    assign ch_valid  = r_ch_valid;
    assign ch_msg    = r_ch_msg;
    assign ch_idx    = r_ch_idx;
    assign ch_last   = r_ch_last;
    assign parity_ok = r_parity_ok;

endmodule
`default_nettype wire

// File: tb/tb_cn_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_cn_serial
// Description : Self-checking bench for cn_serial (DEG=6, Q8.8). Directed
//               scenarios plus randomized checks against a behavioural model.
//               Honours CN_OFFSET_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cn_serial;

    localparam int c_deg = 6;
    localparam int c_w   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             vr_valid;
    logic             vr_ready;
    logic [c_w-1:0]   vr_msg;
    logic             ch_valid;
    logic             ch_ready;
    logic [c_w-1:0]   ch_msg;
    logic [2:0]       ch_idx;
    logic             ch_last;
    logic             parity_ok;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [c_w-1:0]   stim [c_deg];
    logic [c_w-1:0]   expv [c_deg];
    logic             exp_par;

    always #5 clk = ~clk;

    cn_serial #(
        .INT        (8),
        .FRAC       (8),
        .DATA_WIDTH (c_w),
        .DEG        (c_deg),
        .OFFSET     (16'h0040)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .vr_valid  (vr_valid),
        .vr_ready  (vr_ready),
        .vr_msg    (vr_msg),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_msg    (ch_msg),
        .ch_idx    (ch_idx),
        .ch_last   (ch_last),
        .parity_ok (parity_ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: min over the other edges' saturated magnitudes, sign = product of other signs.
    task automatic model();
        int mag [c_deg];
        int v, m, min1, min2, idx1, par;
        for (int k = 0; k < c_deg; k++) begin
            v = int'($signed(stim[k]));
            mag[k] = (v < 0) ? -v : v;
            if (mag[k] > 32767) mag[k] = 32767;
        end
        idx1 = 0;
        for (int k = 1; k < c_deg; k++) if (mag[k] < mag[idx1]) idx1 = k;
        min1 = mag[idx1];
        min2 = 32767;
        for (int k = 0; k < c_deg; k++) if (k != idx1 && mag[k] < min2) min2 = mag[k];
        par = 0;
        for (int k = 0; k < c_deg; k++) par = par ^ int'(stim[k][15]);
        for (int j = 0; j < c_deg; j++) begin
            m = (j == idx1) ? min2 : min1;
`ifdef CN_OFFSET_EN
            m = (m > 64) ? (m - 64) : 0;
`endif
            expv[j] = 16'(((par ^ int'(stim[j][15])) != 0) ? -m : m);
        end
        exp_par = (par == 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_vr_ready"},  32'(vr_ready),  0);
        chk({tag, "_ch_valid"},  32'(ch_valid),  0);
        chk({tag, "_ch_msg"},    32'(ch_msg),    0);
        chk({tag, "_ch_idx"},    32'(ch_idx),    0);
        chk({tag, "_ch_last"},   32'(ch_last),   0);
        chk({tag, "_parity_ok"}, 32'(parity_ok), 0);
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send(input logic [c_w-1:0] m);
        int t = 0;
        vr_valid = 1'b1;
        vr_msg   = m;
        while (!vr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!vr_ready) begin
            chk("vr_ready_timeout", 0, 1);
        end else begin
            @(negedge clk);
        end
        vr_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle before every odd edge, 2 random idles.
    task automatic send_all(input int n, input int gap_mode);
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 1 && (k % 2) == 1) @(negedge clk);
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(stim[k]);
        end
    endtask

    task automatic recv(input int stall_at, input int stall_len, input bit rnd);
        int             n;
        int             t;
        logic [c_w-1:0] s_msg;
        logic [2:0]     s_idx;
        chk("latency_ch_valid", 32'(ch_valid), 1);
        for (int j = 0; j < c_deg; j++) begin
            ch_ready = 1'b0;
            n = (j == stall_at) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            if (n > 0 && ch_valid) begin
                s_msg = ch_msg;
                s_idx = ch_idx;
                repeat (n) @(negedge clk);
                chk($sformatf("stall_msg%0d", j),   32'(ch_msg),   32'(s_msg));
                chk($sformatf("stall_idx%0d", j),   32'(ch_idx),   32'(s_idx));
                chk($sformatf("stall_valid%0d", j), 32'(ch_valid), 1);
            end
            ch_ready = 1'b1;
            t = 0;
            while (!ch_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ch_valid) begin
                chk("ch_valid_timeout", 0, 1);
                ch_ready = 1'b0;
                return;
            end
            chk($sformatf("msg%0d", j),    32'(ch_msg),    32'(expv[j]));
            chk($sformatf("idx%0d", j),    32'(ch_idx),    32'(j));
            chk($sformatf("last%0d", j),   32'(ch_last),   32'(j == c_deg - 1));
            chk($sformatf("parity%0d", j), 32'(parity_ok), 32'(exp_par));
            chk($sformatf("vr_ready_emit%0d", j), 32'(vr_ready), 0);
            @(negedge clk);
        end
        ch_ready = 1'b0;
        chk("ch_valid_after_last", 32'(ch_valid), 0);
    endtask

    task automatic set_scen1();
        stim = '{16'h0200, 16'hFF00, 16'h0300, 16'h0080, 16'hFC00, 16'h0180};
`ifdef CN_OFFSET_EN
        expv = '{16'h0040, 16'hFFC0, 16'h0040, 16'h00C0, 16'hFFC0, 16'h0040};
`else
        expv = '{16'h0080, 16'hFF80, 16'h0080, 16'h0100, 16'hFF80, 16'h0080};
`endif
        exp_par = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        vr_valid = 1'b0;
        vr_msg   = '0;
        ch_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: basic check.
        set_scen1();
        send_all(c_deg, 0);
        recv(-1, 0, 1'b0);

        // Scenario 2: odd number of negative inputs.
        stim = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFE00};
`ifdef CN_OFFSET_EN
        expv = '{16'hFF40, 16'hFF40, 16'hFF40, 16'hFF40, 16'hFF40, 16'h00C0};
`else
        expv = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0100};
`endif
        exp_par = 1'b0;
        send_all(c_deg, 0);
        recv(-1, 0, 1'b0);

        // Scenario 3: tie on the minimum and saturation of the most negative input.
        stim = '{16'h8000, 16'h0040, 16'h0040, 16'h7FFF, 16'h0100, 16'h0200};
        model();
        send_all(c_deg, 0);
        recv(-1, 0, 1'b0);

        // Scenario 4: backpressure at edge 2, gapped input.
        set_scen1();
        send_all(c_deg, 1);
        recv(2, 5, 1'b0);

        // Scenario 5: asynchronous reset after a partial check.
        stim = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        send_all(3, 0);
        #2 rst = 1'b1;
        #1 reset_checks("midreset");
        @(negedge clk);
        reset_checks("midreset_hold");
        rst = 1'b0;
        @(negedge clk);
        set_scen1();
        send_all(c_deg, 0);
        recv(-1, 0, 1'b0);

`ifdef CN_OFFSET_EN
        // Scenario 6: minimum below the offset clamps non-idx1 edges to zero.
        stim = '{16'h0100, 16'hFFD0, 16'h0200, 16'h0300, 16'hFC00, 16'h0500};
        model();
        send_all(c_deg, 0);
        recv(-1, 0, 1'b0);
`endif

        // Randomized checks against the reference model.
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < c_deg; k++) begin
                case ($urandom_range(0, 3))
                    0: stim[k] = 16'($urandom);
                    1: stim[k] = 16'($urandom_range(0, 8)) << 6;
                    2: stim[k] = -(16'($urandom_range(0, 8)) << 6);
                    default: begin
                        case ($urandom_range(0, 3))
                            0: stim[k] = 16'h8000;
                            1: stim[k] = 16'h7FFF;
                            2: stim[k] = 16'h0000;
                            default: stim[k] = 16'hFFC0;
                        endcase
                    end
                endcase
            end
            model();
            send_all(c_deg, 2);
            recv(-1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
